// File: rtl/dac_serial_monitor.sv
// Passive listener on the bias DAC serial pins. Deserialises each frame on
// the main and compensation data lines, applies it on the LDAC strobe and
// keeps a small readback FIFO of every value pair actually loaded.
module dac_serial_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int RB_DEPTH    = 4
) (
  input  logic                    adc_clk,
  input  logic                    reset_n,
  input  logic                    sclk_in,
  input  logic                    cs_n_in,
  input  logic                    din_in,
  input  logic                    din_comp_in,
  input  logic                    ldac_n_in,
  output logic [FRAME_BITS-1:0]   dac_value,
  output logic [FRAME_BITS-1:0]   dac_comp_value,
  output logic                    load_pulse,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic [15:0]             load_count,
  input  logic                    rb_rd_en,
  output logic [2*FRAME_BITS-1:0] rb_dout,
  output logic                    rb_empty,
  output logic [$clog2(RB_DEPTH):0] rb_count,
  output logic                    rb_overflow,
  input  logic                    err_clr
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int PTR_W = $clog2(RB_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [PTR_W:0]   RB_FULL  = (PTR_W+1)'(RB_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} state_e;

  // Synchroniser bit positions: {ldac_n, din_comp, din, cs_n, sclk}
  logic [4:0] sync_q [SYNC_STAGES];
  logic [2:0] edge_prv_q;  // previous synced {ldac_n, cs_n, sclk}

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0]   main_sr_q, main_sr_d, comp_sr_q, comp_sr_d;
  logic [FRAME_BITS-1:0]   sh_main_q, sh_main_d, sh_comp_q, sh_comp_d;
  logic                    shadow_valid_q, shadow_valid_d;
  logic                    pending_q, pending_d;
  logic [FRAME_BITS-1:0]   dac_q, comp_q;
  logic                    load_pulse_q, frame_err_q, overflow_q;
  logic [7:0]              err_count_q;
  logic [15:0]             load_count_q;
  logic [2*FRAME_BITS-1:0] mem_q [RB_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q, count_d;

  logic [4:0] cur;
  logic sclk_rise, cs_fall, cs_rise, ldac_fall;
  logic do_load, err_event, pop_ok, push_ok, push_drop;

  // Input synchroniser chain plus one extra sample for edge detection.
  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
      edge_prv_q <= '1;
    end else begin
      sync_q[0]  <= {ldac_n_in, din_comp_in, din_in, cs_n_in, sclk_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_prv_q <= {sync_q[SYNC_STAGES-1][4], sync_q[SYNC_STAGES-1][1],
                     sync_q[SYNC_STAGES-1][0]};
    end
  end

  assign cur       = sync_q[SYNC_STAGES-1];
  assign sclk_rise =  cur[0] & ~edge_prv_q[0];
  assign cs_fall   = ~cur[1] &  edge_prv_q[1];
  assign cs_rise   =  cur[1] & ~edge_prv_q[1];
  assign ldac_fall = ~cur[4] &  edge_prv_q[2];

  // Frame FSM next state, shift path, shadow update and load decision.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    main_sr_d      = main_sr_q;
    comp_sr_d      = comp_sr_q;
    sh_main_d      = sh_main_q;
    sh_comp_d      = sh_comp_q;
    shadow_valid_d = shadow_valid_q;
    pending_d      = pending_q;
    do_load        = 1'b0;
    err_event      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        main_sr_d = '0;
        comp_sr_d = '0;
        pending_d = 1'b0;
        if ((ldac_fall || pending_q) && shadow_valid_q) do_load = 1'b1;
        if (cs_fall) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A strobe during the frame waits for CHECK to decide its fate.
        if (ldac_fall) pending_d = 1'b1;
        if (sclk_rise && !cur[1]) begin
          main_sr_d = {main_sr_q[FRAME_BITS-2:0], cur[2]};
          comp_sr_d = {comp_sr_q[FRAME_BITS-2:0], cur[3]};
          if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (cs_rise) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (bit_cnt_q == CNT_FULL) begin
          sh_main_d      = main_sr_q;
          sh_comp_d      = comp_sr_q;
          shadow_valid_d = 1'b1;
          pending_d      = pending_q | ldac_fall;
        end else begin
          err_event = 1'b1;
          pending_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (do_load) shadow_valid_d = 1'b0;
  end

  // Readback FIFO handshake: a same-cycle pop frees room for the push.
  always_comb begin
    pop_ok    = rb_rd_en && (count_q != '0);
    push_ok   = do_load && ((count_q != RB_FULL) || pop_ok);
    push_drop = do_load && !push_ok;
    count_d   = count_q;
    if (push_ok && !pop_ok) count_d = count_q + (PTR_W+1)'(1);
    if (!push_ok && pop_ok) count_d = count_q - (PTR_W+1)'(1);
  end

  // Control, status and pointer registers.
  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      main_sr_q      <= '0;
      comp_sr_q      <= '0;
      sh_main_q      <= '0;
      sh_comp_q      <= '0;
      shadow_valid_q <= 1'b0;
      pending_q      <= 1'b0;
      dac_q          <= '0;
      comp_q         <= '0;
      load_pulse_q   <= 1'b0;
      load_count_q   <= '0;
      frame_err_q    <= 1'b0;
      err_count_q    <= '0;
      overflow_q     <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      main_sr_q      <= main_sr_d;
      comp_sr_q      <= comp_sr_d;
      sh_main_q      <= sh_main_d;
      sh_comp_q      <= sh_comp_d;
      shadow_valid_q <= shadow_valid_d;
      pending_q      <= pending_d;
      load_pulse_q   <= do_load;
      if (do_load) begin
        dac_q        <= sh_main_q;
        comp_q       <= sh_comp_q;
        load_count_q <= load_count_q + 16'd1;
      end
      if (err_clr) begin
        frame_err_q <= 1'b0;
        err_count_q <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (err_event) begin
          frame_err_q <= 1'b1;
          if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
        if (push_drop) overflow_q <= 1'b1;
      end
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge adc_clk) begin
    // NOTE: storage is not reset; rb_dout is forced to zero while empty instead.
    if (push_ok) mem_q[wr_ptr_q] <= {sh_comp_q, sh_main_q};
  end

  assign dac_value      = dac_q;
  assign dac_comp_value = comp_q;
  assign load_pulse     = load_pulse_q;
  assign frame_err      = frame_err_q;
  assign err_count      = err_count_q;
  assign load_count     = load_count_q;
  assign rb_empty       = (count_q == '0);
  assign rb_count       = count_q;
  assign rb_overflow    = overflow_q;
  assign rb_dout        = rb_empty ? '0 : mem_q[rd_ptr_q];

endmodule
